// File: rtl/uart_receiver.sv
// UART receive path: synchronizes rxd, frames 8N1 bytes with a mid-bit sampling
// timer, and hands bytes over through a single-entry valid/ack holding register.
module uart_receiver #(
  parameter int UART_PERIOD      = 868,
  parameter int UART_PERIOD_BITS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data_received,
  output logic       data_received_valid,
  input  logic       data_received_ack,
  output logic       framing_error,
  output logic       overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  localparam logic [UART_PERIOD_BITS-1:0] HALF_RELOAD = UART_PERIOD_BITS'(UART_PERIOD / 2 - 1);
  localparam logic [UART_PERIOD_BITS-1:0] FULL_RELOAD = UART_PERIOD_BITS'(UART_PERIOD - 1);

  state_t                      state;
  state_t                      state_next;
  logic                        rxd_meta;
  logic                        rxd_s;
  logic [UART_PERIOD_BITS-1:0] timer;
  logic [2:0]                  bit_cnt;
  logic [7:0]                  shift_reg;

  logic sample;
  logic timer_run;
  logic timer_load_half;
  logic timer_load_full;
  logic bit_clear;
  logic shift_en;
  logic load_byte;
  logic drop_byte;
  logic frame_bad;

  // Synchronizer flops reset high so an idle line never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign sample = (timer == '0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rxd_s) state_next = START;
      START:     if (sample) state_next = rxd_s ? IDLE : DATA;
      DATA:      if (sample && bit_cnt == 3'd7) state_next = STOP;
      STOP:      if (sample) state_next = rxd_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxd_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    timer_run       = 1'b0;
    timer_load_half = 1'b0;
    timer_load_full = 1'b0;
    bit_clear       = 1'b0;
    shift_en        = 1'b0;
    load_byte       = 1'b0;
    drop_byte       = 1'b0;
    frame_bad       = 1'b0;
    case (state)
      IDLE: timer_load_half = !rxd_s;
      START: begin
        timer_run       = 1'b1;
        timer_load_full = sample && !rxd_s;
        bit_clear       = sample && !rxd_s;
      end
      DATA: begin
        timer_run       = 1'b1;
        timer_load_full = sample;
        shift_en        = sample;
      end
      // A full holding register only blocks the new byte if it is not being acked now.
      STOP: begin
        timer_run = 1'b1;
        load_byte = sample && rxd_s && (!data_received_valid || data_received_ack);
        drop_byte = sample && rxd_s && data_received_valid && !data_received_ack;
        frame_bad = sample && !rxd_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (timer_load_half)              timer <= HALF_RELOAD;
      else if (timer_load_full)         timer <= FULL_RELOAD;
      else if (timer_run && !sample)    timer <= timer - UART_PERIOD_BITS'(1);
      if (bit_clear)     bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shift_reg <= {rxd_s, shift_reg[7:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_received       <= '0;
      data_received_valid <= 1'b0;
      framing_error       <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      if (load_byte) data_received <= shift_reg;
      if (load_byte)              data_received_valid <= 1'b1;
      else if (data_received_ack) data_received_valid <= 1'b0;
      framing_error <= frame_bad;
      overrun       <= drop_byte;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 16 clocks per bit: table-driven frames
// plus hand-written glitch, overrun, same-cycle-ack and mid-frame reset sequences.
module tb_uart_receiver;

  localparam int BIT_T = 16;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         low_hold;
    logic       expect_byte;
    int         expect_fe;
  } rx_vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       data_received_ack;
  logic [7:0] data_received;
  logic       data_received_valid;
  logic       framing_error;
  logic       overrun;

  int         n_vec  = 0;
  int         n_miss = 0;
  int         cyc    = 0;
  int         start_cyc;
  int         deliver_cyc;
  int         fe_count = 0;
  int         ov_count = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  rx_vec_t    vecs[6];

  uart_receiver #(.UART_PERIOD(BIT_T), .UART_PERIOD_BITS(10)) dut (
    .clk                 (clk),
    .reset               (reset),
    .rxd                 (rxd),
    .data_received       (data_received),
    .data_received_valid (data_received_valid),
    .data_received_ack   (data_received_ack),
    .framing_error       (framing_error),
    .overrun             (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A delivery is valid rising, or new data appearing while valid stays high.
  always @(negedge clk) begin
    if (!reset) begin
      if (framing_error) fe_count <= fe_count + 1;
      if (overrun)       ov_count <= ov_count + 1;
      if (data_received_valid && (!prev_valid || data_received != prev_data)) begin
        got_q.push_back(data_received);
        deliver_cyc <= cyc;
      end
    end
    prev_valid <= data_received_valid;
    prev_data  <= data_received;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic compare_deliveries();
    logic [7:0] got;
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no delivery", got);
      end else begin
        checkOutput("rx_byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
      end
    end
    checkOutput("pending_bytes", exp_q.size(), 0);
  endtask

  task automatic ack_pulse();
    data_received_ack = 1'b1;
    tick();
    data_received_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic ack_at_stop);
    rxd = 1'b0;
    start_cyc = cyc;
    repeat (BIT_T) tick();
    for (int b = 0; b < 8; b++) begin
      rxd = data[b];
      repeat (BIT_T) tick();
    end
    rxd = stop_bit;
    if (ack_at_stop) begin
      repeat (BIT_T - 6) tick();
      ack_pulse();
      repeat (5) tick();
    end else begin
      repeat (BIT_T) tick();
    end
  endtask

  task automatic applyStimulus(input rx_vec_t v);
    int fe0;
    int ov0;
    int lat;
    fe0 = fe_count;
    ov0 = ov_count;
    if (v.expect_byte) exp_q.push_back(v.data);
    send_frame(v.data, v.stop_bit, 1'b0);
    rxd = 1'b0;
    repeat (v.low_hold) tick();
    rxd = 1'b1;
    repeat (24) tick();
    compare_deliveries();
    checkOutput("fe_pulses", fe_count - fe0, v.expect_fe);
    checkOutput("ov_pulses", ov_count - ov0, 0);
    checkOutput("valid", {31'd0, data_received_valid}, {31'd0, v.expect_byte});
    if (v.expect_byte) begin
      checkOutput("data", {24'd0, data_received}, {24'd0, v.data});
      lat = deliver_cyc - start_cyc;
      checkOutput($sformatf("latency_%0d_in_150_156", lat), {31'd0, (lat >= 150 && lat <= 156)}, 1);
    end
    ack_pulse();
    tick();
    checkOutput("valid_after_ack", {31'd0, data_received_valid}, 0);
  endtask

  initial begin
    int fe0;
    int ov0;
    vecs[0] = '{8'hA5, 1'b1, 0,  1'b1, 0};
    vecs[1] = '{8'h00, 1'b1, 0,  1'b1, 0};
    vecs[2] = '{8'hFF, 1'b1, 0,  1'b1, 0};
    vecs[3] = '{8'h3C, 1'b0, 40, 1'b0, 1};
    vecs[4] = '{8'h81, 1'b1, 0,  1'b1, 0};
    vecs[5] = '{8'h5A, 1'b1, 0,  1'b1, 0};

    reset = 1'b1;
    rxd = 1'b1;
    data_received_ack = 1'b0;
    repeat (3) tick();
    checkOutput("reset_data", {24'd0, data_received}, 0);
    checkOutput("reset_valid", {31'd0, data_received_valid}, 0);
    checkOutput("reset_fe", {31'd0, framing_error}, 0);
    checkOutput("reset_ov", {31'd0, overrun}, 0);
    reset = 1'b0;
    repeat (5) tick();

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Short low glitch must die in START.
    fe0 = fe_count;
    ov0 = ov_count;
    rxd = 1'b0;
    repeat (4) tick();
    rxd = 1'b1;
    repeat (40) tick();
    compare_deliveries();
    checkOutput("glitch_valid", {31'd0, data_received_valid}, 0);
    checkOutput("glitch_fe", fe_count - fe0, 0);
    checkOutput("glitch_ov", ov_count - ov0, 0);

    // Second byte with no ack is dropped as an overrun.
    fe0 = fe_count;
    ov0 = ov_count;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (24) tick();
    compare_deliveries();
    checkOutput("ovr_pulses", ov_count - ov0, 1);
    checkOutput("ovr_fe", fe_count - fe0, 0);
    checkOutput("ovr_valid", {31'd0, data_received_valid}, 1);
    checkOutput("ovr_data_kept", {24'd0, data_received}, 32'h11);
    ack_pulse();
    tick();
    checkOutput("ovr_valid_after_ack", {31'd0, data_received_valid}, 0);

    // Ack in the same cycle as the stop sample lets the new byte in.
    ov0 = ov_count;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 1'b1);
    repeat (24) tick();
    compare_deliveries();
    checkOutput("same_ack_ov", ov_count - ov0, 0);
    checkOutput("same_ack_valid", {31'd0, data_received_valid}, 1);
    checkOutput("same_ack_data", {24'd0, data_received}, 32'h22);
    ack_pulse();
    tick();
    checkOutput("same_ack_valid_after_ack", {31'd0, data_received_valid}, 0);

    // Reset in the middle of bit 4 of 0xFF abandons the frame.
    rxd = 1'b0;
    repeat (BIT_T) tick();
    rxd = 1'b1;
    repeat (4 * BIT_T + 8) tick();
    reset = 1'b1;
    repeat (2) tick();
    checkOutput("midreset_data", {24'd0, data_received}, 0);
    checkOutput("midreset_valid", {31'd0, data_received_valid}, 0);
    checkOutput("midreset_fe", {31'd0, framing_error}, 0);
    checkOutput("midreset_ov", {31'd0, overrun}, 0);
    reset = 1'b0;
    repeat (6 * BIT_T) tick();
    checkOutput("midreset_no_byte", got_q.size(), 0);
    checkOutput("midreset_valid_after", {31'd0, data_received_valid}, 0);
    applyStimulus(vecs[5]);

    checkOutput("final_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter UART_PERIOD, default 868, meaning clk cycles per bit (legal range 4 to 2**UART_PERIOD_BITS-1).
REQ-002 SHALL have parameter UART_PERIOD_BITS, default 10, meaning width of the bit timer.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rxd  input  1  board RxD pin; asynchronous to clk; idle high.
REQ-006 SHALL have port data_received  output  8  last accepted byte, LSB received first.
REQ-007 SHALL have port data_received_valid  output  1  high while data_received holds an unconsumed byte.
REQ-008 SHALL have port data_received_ack  input  1  consumer pulse; consumes the held byte.
REQ-009 SHALL have port framing_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because the buffer is still full.

Function
REQ-011 SHALL pass rxd through a two-flop synchronizer (both flops reset to 1); all decisions SHALL use only the synchronized value rxd_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH, using one down-counting timer of UART_PERIOD_BITS bits and one 3-bit bit counter.
REQ-013 IDLE: when rxd_s==0, SHALL load timer with UART_PERIOD/2-1 (integer division) and go to START; otherwise stay in IDLE.
REQ-014 In START, DATA and STOP, the timer SHALL decrement each cycle while non-zero; a "sample" occurs on the cycle the timer equals 0.
REQ-015 START sample: if rxd_s==0, SHALL go to DATA, clear the bit counter and load timer with UART_PERIOD-1; if rxd_s==1 (glitch), SHALL return to IDLE with no output activity.
REQ-016 DATA sample: SHALL shift rxd_s into bit 7 of the shift register (right shift, LSB first), increment the bit counter and reload timer with UART_PERIOD-1; after the 8th sample (counter wraps 7->0), SHALL go to STOP.
REQ-017 STOP sample with rxd_s==1 and (data_received_valid==0 or data_received_ack==1): SHALL copy the shift register to data_received, set data_received_valid and go to IDLE.
REQ-018 STOP sample with rxd_s==1 while data_received_valid==1 and data_received_ack==0: SHALL drop the new byte, leave data_received unchanged, pulse overrun for one cycle and go to IDLE.
REQ-019 STOP sample with rxd_s==0: SHALL discard the byte, pulse framing_error for one cycle, leave data_received/valid unchanged and go to WAIT_HIGH.
REQ-020 WAIT_HIGH: SHALL stay until rxd_s==1, then go to IDLE; a held-low line (break) SHALL NOT produce further bytes or errors.
REQ-021 data_received_ack with data_received_valid high SHALL clear valid on the next edge, unless a byte is loaded in the same cycle per REQ-017, in which case valid SHALL stay high with the new data.
REQ-022 data_received_ack while data_received_valid is low SHALL be ignored.
REQ-023 data_received SHALL be stable whenever data_received_valid is high, until the ack cycle.
REQ-024 The byte SHALL be accepted only on the STOP sample, about 9.5*UART_PERIOD + 3 cycles after the rxd falling edge.

Reset
REQ-025 While reset is high, the block SHALL asynchronously go to IDLE; data_received=0, data_received_valid=0, framing_error=0, overrun=0, timer=0, bit counter=0, shift register=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait for a new falling edge on rxd_s (a low line after release counts as a start).

Verification (bench with UART_PERIOD=16, bit time 16 clk)
REQ-027 Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> data_received=0xA5 and valid high within 9.5*16+4 cycles of the falling edge; no error pulses.
REQ-028 Low glitch of 4 cycles on an idle line -> START rejects it; valid, framing_error and overrun remain 0.
REQ-029 Send 0x3C with stop bit 0, then hold rxd low 40 cycles, then high -> exactly one framing_error pulse, no valid, then 0x81 received correctly.
REQ-030 Send 0x11 then 0x22 with no ack -> valid high with 0x11, exactly one overrun pulse at the second stop sample, data_received stays 0x11; ack clears valid.
REQ-031 Ack in the same cycle as the 0x22 STOP sample -> valid stays high, data_received=0x22, no overrun.
REQ-032 Assert reset at bit 4 of 0xFF, release, then send 0x5A -> all outputs 0 during reset, then only 0x5A is delivered.
